game_fsm: RTL and testbench
===========================

GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, frame_tick pulses per timer second.
REQ-002 SHALL have parameter STAGE_SECONDS, default 60, stage time limit loaded on stage entry.
REQ-003 SHALL have parameter SUCCESS_FRAMES, default 120, dwell in SUCCESS1/SUCCESS2 before auto-advance.
REQ-004 SHALL have parameter INVULN_FRAMES, default 30, hit-immunity window after a damaging hit.
REQ-005 SHALL have parameter MAX_HEART, default 3, hearts loaded on STAGE1 entry.
REQ-006 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port frame_tick  in  1  one-cycle pulse per displayed frame, at vertical blank.
REQ-009 SHALL have port btn_start  in  1  one-cycle pulse, already debounced.
REQ-010 SHALL have port btn_staff  in  1  one-cycle pulse, already debounced.
REQ-011 SHALL have port key_pickup  in  1  one-cycle pulse, player touched key.
REQ-012 SHALL have port door_enter  in  1  one-cycle pulse, player touched door.
REQ-013 SHALL have port hit  in  1  one-cycle pulse, player touched hazard.
REQ-014 SHALL have port state  out  4  current game state, consumed by display stage.
REQ-015 SHALL have port heart  out  2  remaining hearts, 0..MAX_HEART.
REQ-016 SHALL have port key_find  out  1  key collected in current stage.
REQ-017 SHALL have port isLocked  out  1  door locked; always the inverse of key_find.
REQ-018 SHALL have port time_left  out  6  remaining stage seconds.
REQ-019 SHALL have port play_valid  out  1  high only in STAGE1/STAGE2/STAGE3.

Function
REQ-020 SHALL encode states TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8; codes 9..15 go to TITLE next cycle.
REQ-021 SHALL, in TITLE: btn_start -> STAGE1; btn_staff -> STAFF; both same cycle -> STAGE1.
REQ-022 SHALL, in STAFF: btn_start or btn_staff -> TITLE.
REQ-023 SHALL, on every STAGEn entry cycle, load key_find=0, time_left=STAGE_SECONDS, frame and invuln counters=0; heart=MAX_HEART on STAGE1 entry only, carried into STAGE2/3.
REQ-024 SHALL set key_find=1 one cycle after key_pickup in a STAGE state; repeated pickups ignored.
REQ-025 SHALL move STAGEn -> SUCCESSn on door_enter when key_find=1; door_enter with key_find=0 ignored.
REQ-026 SHALL, on hit with invuln counter=0 in a STAGE state, decrement heart and load invuln counter with INVULN_FRAMES; counter decrements per frame_tick; hits while nonzero ignored.
REQ-027 SHALL go to FAIL on an accepted hit when heart=1 (heart becomes 0).
REQ-028 SHALL count frame_tick modulo FRAMES_PER_SEC in STAGE states and decrement time_left on wrap; time_left reaching 0 -> FAIL same cycle; no underflow.
REQ-029 SHALL give priority valid door_enter > fatal hit > timer expiry when coincident.
REQ-030 SHALL, in SUCCESS1/SUCCESS2, count SUCCESS_FRAMES frame_ticks then enter STAGE2/STAGE3; buttons ignored.
REQ-031 SHALL, in SUCCESS3 or FAIL, return to TITLE on btn_start.
REQ-032 SHALL drive all outputs from registers; no combinational input-to-output path.

Reset
REQ-033 SHALL on rst, at any time including mid-stage, force state=TITLE, heart=MAX_HEART, key_find=0, isLocked=1, time_left=STAGE_SECONDS, play_valid=0, all counters 0.
REQ-034 SHALL take first post-reset transition on first clk edge after rst deasserts.

Structure
REQ-035 SHALL place state codes and MAX_HEART/STAGE_SECONDS defaults in the shared game package used by the display stage.
REQ-036 SHALL contain one sub-module, game_timer: frame-to-second divider plus seconds down-counter with load and expire pulse.

Verification
REQ-037 SHALL test rst, btn_start -> state=2, heart=3, time_left=60, play_valid=1, isLocked=1.
REQ-038 SHALL test STAGE1 door_enter before key_pickup -> stays 2; key_pickup then door_enter -> 3; after 120 frame_ticks -> 4, key_find=0, heart unchanged.
REQ-039 SHALL test hits 1 apart in frames then 31 frames apart -> heart 3->2 (second ignored) ->1; third accepted hit -> state=8, heart=0.
REQ-040 SHALL test 3600 frame_ticks in STAGE1 without exit -> time_left=0, state=8; btn_start -> 0.
REQ-041 SHALL test door_enter (key held) and fatal hit same cycle -> SUCCESSn, heart unchanged.
REQ-042 SHALL test rst asserted in STAGE2 mid-invulnerability -> TITLE and all REQ-033 values immediately.

Source files
------------

// File: rtl/game_fsm_pkg.sv
// game_fsm_pkg: shared game state codes and default limits, also used by the display stage.
package game_fsm_pkg;

    typedef enum logic [3:0] {
        TITLE    = 4'd0,
        STAFF    = 4'd1,
        STAGE1   = 4'd2,
        SUCCESS1 = 4'd3,
        STAGE2   = 4'd4,
        SUCCESS2 = 4'd5,
        STAGE3   = 4'd6,
        SUCCESS3 = 4'd7,
        FAIL     = 4'd8
    } state_t;

    localparam int MAX_HEART_DEF     = 3;
    localparam int STAGE_SECONDS_DEF = 60;

    function automatic logic is_stage(state_t s);
        return s inside {STAGE1, STAGE2, STAGE3};
    endfunction

endpackage

// File: rtl/game_timer.sv
// game_timer: frame-to-second divider plus stage seconds down-counter.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : reload seconds to STAGE_SECONDS and clear the frame divider
//   run         : count frame ticks (high while a stage is being played)
//   frame_tick  : one pulse per displayed frame
//   secs        : remaining seconds (registered)
//   expire      : combinational pulse on the tick that takes secs from 1 to 0
module game_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int STAGE_SECONDS  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    input  logic       frame_tick,
    output logic [5:0] secs,
    output logic       expire
);

    localparam int FW = $clog2(FRAMES_PER_SEC + 1);

    logic [FW-1:0] frame_cnt;
    logic          wrap;

    assign wrap   = run && frame_tick && frame_cnt == FW'(FRAMES_PER_SEC - 1);
    // Expire is combinational so the FSM can enter FAIL on the same edge secs hits 0.
    assign expire = wrap && secs == 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secs      <= 6'(STAGE_SECONDS);
            frame_cnt <= '0;
        end else if (load) begin
            secs      <= 6'(STAGE_SECONDS);
            frame_cnt <= '0;
        end else if (run && frame_tick) begin
            frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            if (wrap && secs != 6'd0)
                secs <= secs - 6'd1;
        end
    end

endmodule

// File: rtl/game_fsm.sv
// game_fsm: top-level game flow controller (title, stages, success screens, fail).
//   clk, rst               : clock, asynchronous active-high reset
//   frame_tick             : one pulse per displayed frame
//   btn_start, btn_staff   : debounced button pulses
//   key_pickup, door_enter : player touched key / door
//   hit                    : player touched a hazard
//   state                  : current game state code
//   heart                  : remaining hearts
//   key_find, isLocked     : key collected / door still locked
//   time_left              : remaining stage seconds
//   play_valid             : a stage is being played
module game_fsm
    import game_fsm_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int STAGE_SECONDS  = STAGE_SECONDS_DEF,
    parameter int SUCCESS_FRAMES = 120,
    parameter int INVULN_FRAMES  = 30,
    parameter int MAX_HEART      = MAX_HEART_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_staff,
    input  logic       key_pickup,
    input  logic       door_enter,
    input  logic       hit,
    output logic [3:0] state,
    output logic [1:0] heart,
    output logic       key_find,
    output logic       isLocked,
    output logic [5:0] time_left,
    output logic       play_valid
);

    localparam int IW = $clog2(INVULN_FRAMES + 2);
    localparam int SW = $clog2(SUCCESS_FRAMES + 1);

    state_t        cur, nxt;
    logic [1:0]    heart_d;
    logic          key_d;
    logic [IW-1:0] inv, inv_d;
    logic [SW-1:0] succ, succ_d;
    logic          load, expire, door_ok, hit_ok;

    game_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC),
        .STAGE_SECONDS (STAGE_SECONDS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .run       (is_stage(cur)),
        .frame_tick(frame_tick),
        .secs      (time_left),
        .expire    (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= TITLE;
            heart    <= 2'(MAX_HEART);
            key_find <= 1'b0;
            inv      <= '0;
            succ     <= '0;
        end else begin
            cur      <= nxt;
            heart    <= heart_d;
            key_find <= key_d;
            inv      <= inv_d;
            succ     <= succ_d;
        end
    end

    assign state      = cur;
    assign isLocked   = ~key_find;
    assign play_valid = is_stage(cur);

    always_comb begin
        nxt     = cur;
        heart_d = heart;
        key_d   = key_find;
        inv_d   = inv;
        succ_d  = '0;
        load    = 1'b0;
        door_ok = door_enter && key_find;
        hit_ok  = hit && inv == '0 && heart != 2'd0;
        case (cur)
            TITLE:    nxt = btn_start ? STAGE1 : btn_staff ? STAFF : TITLE;
            STAFF:    nxt = (btn_start || btn_staff) ? TITLE : STAFF;
            STAGE1, STAGE2, STAGE3: begin
                key_d = key_find | key_pickup;
                inv_d = (frame_tick && inv != '0) ? inv - 1'b1 : inv;
                // Stage and success codes are adjacent, so +1 selects SUCCESSn.
                if (door_ok)
                    nxt = state_t'(cur + 4'd1);
                else begin
                    if (hit_ok) begin
                        heart_d = heart - 2'd1;
                        inv_d   = IW'(INVULN_FRAMES);
                    end
                    if ((hit_ok && heart == 2'd1) || expire)
                        nxt = FAIL;
                end
            end
            SUCCESS1, SUCCESS2: begin
                succ_d = frame_tick ? succ + 1'b1 : succ;
                if (frame_tick && succ == SW'(SUCCESS_FRAMES - 1)) begin
                    nxt    = state_t'(cur + 4'd1);
                    succ_d = '0;
                end
            end
            SUCCESS3, FAIL: nxt = btn_start ? TITLE : cur;
            default:  nxt = TITLE;
        endcase
        // Entering any stage restarts its per-stage bookkeeping; hearts refill only for STAGE1.
        if (is_stage(nxt) && nxt != cur) begin
            load  = 1'b1;
            key_d = 1'b0;
            inv_d = '0;
            if (nxt == STAGE1)
                heart_d = 2'(MAX_HEART);
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed scoreboard bench for game_fsm.
module tb_game_fsm;

    logic       clk = 1'b0, rst = 1'b1;
    logic       frame_tick = 1'b0, btn_start = 1'b0, btn_staff = 1'b0;
    logic       key_pickup = 1'b0, door_enter = 1'b0, hit = 1'b0;
    logic [3:0] state;
    logic [1:0] heart;
    logic       key_find, isLocked, play_valid;
    logic [5:0] time_left;

    typedef struct {
        string name;
        int    st;
        int    hr;
        int    kf;
        int    tl;
        int    pv;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    game_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .btn_start (btn_start),
        .btn_staff (btn_staff),
        .key_pickup(key_pickup),
        .door_enter(door_enter),
        .hit       (hit),
        .state     (state),
        .heart     (heart),
        .key_find  (key_find),
        .isLocked  (isLocked),
        .time_left (time_left),
        .play_valid(play_valid)
    );

    task automatic cmp(input string n, input string f, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s.%s got=%0d want=%0d", n, f, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "state", int'(state), e.st);
            cmp(e.name, "heart", int'(heart), e.hr);
            cmp(e.name, "key_find", int'(key_find), e.kf);
            cmp(e.name, "isLocked", int'(isLocked), e.kf != 0 ? 0 : 1);
            cmp(e.name, "time_left", int'(time_left), e.tl);
            cmp(e.name, "play_valid", int'(play_valid), e.pv);
        end
    end

    task automatic ex(input string n, input int st, input int hr, input int kf, input int tl, input int pv);
        exp_t e;
        e.name = n; e.st = st; e.hr = hr; e.kf = kf; e.tl = tl; e.pv = pv;
        q.push_back(e);
    endtask

    task automatic cyc(input logic ft, input logic s, input logic sf, input logic kp, input logic de, input logic h);
        frame_tick = ft; btn_start = s; btn_staff = sf; key_pickup = kp; door_enter = de; hit = h;
        @(posedge clk);
        #1;
        frame_tick = 0; btn_start = 0; btn_staff = 0; key_pickup = 0; door_enter = 0; hit = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        ex("reset", 0, 3, 0, 60, 0);
        @(posedge clk);
        #1 rst = 0;
        cyc(0, 1, 0, 0, 0, 0); ex("start", 2, 3, 0, 60, 1);
        cyc(0, 0, 0, 0, 1, 0); ex("door_nokey", 2, 3, 0, 60, 1);
        cyc(0, 0, 0, 1, 0, 0); ex("key", 2, 3, 1, 60, 1);
        cyc(0, 0, 0, 0, 1, 0); ex("door_key", 3, 3, 1, 60, 0);
        cyc(0, 1, 0, 0, 0, 0); ex("succ_btn", 3, 3, 1, 60, 0);
        tick(119);             ex("succ_119", 3, 3, 1, 60, 0);
        tick(1);               ex("stage2", 4, 3, 0, 60, 1);
        cyc(0, 0, 0, 0, 0, 1); ex("hit1", 4, 2, 0, 60, 1);
        tick(1);
        cyc(0, 0, 0, 0, 0, 1); ex("hit_immune", 4, 2, 0, 60, 1);
        tick(31);
        cyc(0, 0, 0, 0, 0, 1); ex("hit2", 4, 1, 0, 60, 1);
        tick(30);              ex("sec_wrap", 4, 1, 0, 59, 1);
        cyc(0, 0, 0, 1, 0, 0); ex("key2", 4, 1, 1, 59, 1);
        cyc(0, 0, 0, 0, 1, 1); ex("door_vs_hit", 5, 1, 1, 59, 0);
        tick(120);             ex("stage3", 6, 1, 0, 60, 1);
        cyc(0, 0, 0, 0, 0, 1); ex("fatal_hit", 8, 0, 0, 60, 0);
        cyc(0, 0, 1, 0, 0, 0); ex("fail_staff", 8, 0, 0, 60, 0);
        cyc(0, 1, 0, 0, 0, 0); ex("fail_title", 0, 0, 0, 60, 0);
        cyc(0, 1, 0, 0, 0, 0); ex("restart", 2, 3, 0, 60, 1);
        tick(3599);            ex("time_1", 2, 3, 0, 1, 1);
        tick(1);               ex("time_out", 8, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); ex("timeout_title", 0, 3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0); ex("staff", 1, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); ex("staff_start", 0, 3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0); ex("staff2", 1, 3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0); ex("staff_staff", 0, 3, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0); ex("both_btn", 2, 3, 0, 60, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0); ex("exit1", 3, 3, 1, 60, 0);
        tick(120);             ex("stage2b", 4, 3, 0, 60, 1);
        cyc(0, 0, 0, 0, 0, 1);
        tick(2);
        cyc(0, 0, 0, 1, 0, 0); ex("pre_rst", 4, 2, 1, 60, 1);
        tick(3);
        #1 rst = 1;
        #1 ex("rst_mid", 0, 3, 0, 60, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 0;
        cyc(0, 1, 0, 0, 0, 0); ex("post_rst", 2, 3, 0, 60, 1);
        cyc(0, 0, 0, 0, 0, 1); ex("post_rst_hit", 2, 2, 0, 60, 1);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
